rdid_top: RTL and testbench

RDID_TOP -- requirements
Module: rdid_top

---
 rtl/rdid_top.sv | 247 ++++++++++++++++++++++++
 tb/tb_rdid_top.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdid_top.sv
// rdid_top: reads the 3-byte JEDEC ID of an SPI flash on a button
// press and shows one selected ID byte on eight LEDs.
`timescale 1ns/1ps

module led_mux (
   input  logic [1:0] sel,
   input  logic [7:0] mem_cap,
   input  logic [7:0] mem_type,
   input  logic [7:0] man_id,
   output logic [7:0] LED
);

   // Pure combinational byte select; 11 lights every LED.
   always_comb begin
      LED = 8'hFF;
      unique case (sel)
         2'b00:   LED = mem_cap;
         2'b01:   LED = mem_type;
         2'b10:   LED = man_id;
         default: LED = 8'hFF;
      endcase
   end

endmodule

module rdid_top #(
   parameter int DEBOUNCE_BITS = 16,
   parameter int SPI_DIV       = 4
) (
   input  logic       CCLK,
   input  logic       reset_btn,
   input  logic       get_rdid_btn,
   input  logic [1:0] SW,
   input  logic       SPIMISO,
   output logic       SPICLK,
   output logic       SPIMOSI,
   output logic       chip_select,
   output logic       LD0,
   output logic       LD1,
   output logic       LD2,
   output logic       LD3,
   output logic       LD4,
   output logic       LD5,
   output logic       LD6,
   output logic       LD7
);

   localparam int DW = $clog2(SPI_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);
   localparam logic [DW-1:0] DIV_MID  = DW'(SPI_DIV / 2 - 1);
   localparam logic [7:0]    RDID_CMD = 8'h9F;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      CMD,
      READ,
      CS_HOLD,
      LATCH
   } state_t;

   logic rst_meta;
   logic rst_n;

   logic                     btn_meta;
   logic                     btn_s;
   logic [DEBOUNCE_BITS-1:0] db_cnt;
   logic                     db_lvl;
   logic                     db_prev;
   logic                     start;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    bit_q, bit_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          cs_q, cs_d;
   logic [23:0]   rx_q, rx_d;
   logic [7:0]    man_id_q, man_id_d;
   logic [7:0]    mem_type_q, mem_type_d;
   logic [7:0]    mem_cap_q, mem_cap_d;
   logic          div_end;
   logic          div_mid;
   logic [7:0]    LED;

   // Reset asserts at once but releases only on a CCLK edge.
   always_ff @(posedge CCLK or negedge reset_btn) begin
      if (!reset_btn) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   // Button debouncer: level accepted after a full stable count.
   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         db_cnt   <= '0;
         db_lvl   <= 1'b0;
         db_prev  <= 1'b0;
      end else begin
         btn_meta <= get_rdid_btn;
         btn_s    <= btn_meta;
         db_prev  <= db_lvl;
         if (btn_meta != btn_s)
            db_cnt <= '0;
         else if (db_cnt != '1)
            db_cnt <= db_cnt + 1'b1;
         if (db_cnt == '1)
            db_lvl <= btn_s;
      end
   end

   assign start = db_lvl & ~db_prev;

   // SPI master state and ID registers.
   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         rx_q       <= '0;
         man_id_q   <= '0;
         mem_type_q <= '0;
         mem_cap_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
         rx_q       <= rx_d;
         man_id_q   <= man_id_d;
         mem_type_q <= mem_type_d;
         mem_cap_q  <= mem_cap_d;
      end
   end

   assign div_end = (div_q == DIV_LAST);
   assign div_mid = (div_q == DIV_MID);

   // Next-state logic: SPICLK rises mid-period, falls at period end.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      rx_d       = rx_q;
      man_id_d   = man_id_q;
      mem_type_d = mem_type_q;
      mem_cap_d  = mem_cap_q;
      unique case (state_q)
         IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
            mosi_d = 1'b0;
            div_d  = '0;
            if (start) begin
               state_d = CS_SETUP;
               cs_d    = 1'b0;
            end
         end
         CS_SETUP: begin
            div_d = div_q + 1'b1;
            if (div_end) begin
               state_d = CMD;
               div_d   = '0;
               bit_d   = '0;
               mosi_d  = RDID_CMD[7];
            end
         end
         CMD, READ: begin
            div_d = div_q + 1'b1;
            if (div_mid) begin
               sclk_d = 1'b1;
               if (state_q == READ)
                  rx_d = {rx_q[22:0], SPIMISO};
            end
            if (div_end) begin
               div_d  = '0;
               sclk_d = 1'b0;
               bit_d  = bit_q + 5'd1;
               if (state_q == CMD) begin
                  if (bit_q == 5'd7) begin
                     state_d = READ;
                     bit_d   = '0;
                     mosi_d  = 1'b0;
                  end else begin
                     mosi_d = RDID_CMD[3'd6 - bit_q[2:0]];
                  end
               end else if (bit_q == 5'd23) begin
                  state_d = CS_HOLD;
                  bit_d   = '0;
               end
            end
         end
         CS_HOLD: begin
            sclk_d = 1'b0;
            div_d  = div_q + 1'b1;
            if (div_end) begin
               state_d = LATCH;
               div_d   = '0;
               cs_d    = 1'b1;
            end
         end
         LATCH: begin
            man_id_d   = rx_q[23:16];
            mem_type_d = rx_q[15:8];
            mem_cap_d  = rx_q[7:0];
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign SPICLK      = sclk_q;
   assign SPIMOSI     = mosi_q;
   assign chip_select = cs_q;

   led_mux ledMux (
      .sel      (SW),
      .mem_cap  (mem_cap_q),
      .mem_type (mem_type_q),
      .man_id   (man_id_q),
      .LED      (LED)
   );

   assign LD0 = LED[0];
   assign LD1 = LED[1];
   assign LD2 = LED[2];
   assign LD3 = LED[3];
   assign LD4 = LED[4];
   assign LD5 = LED[5];
   assign LD6 = LED[6];
   assign LD7 = LED[7];

endmodule

// File: tb/tb_rdid_top.sv
// tb_rdid_top: randomized presses against a flash model, with a
// frame scoreboard and LED checks against the expected ID bytes.
`timescale 1ns/1ps

module tb_rdid_top;

   localparam int DB = 5;
   localparam int T  = 1 << DB;

   logic       CCLK;
   logic       reset_btn;
   logic       get_rdid_btn;
   logic [1:0] SW;
   logic       SPIMISO;
   logic       SPICLK;
   logic       SPIMOSI;
   logic       chip_select;
   logic       LD0, LD1, LD2, LD3, LD4, LD5, LD6, LD7;
   logic [7:0] led;

   int          compared;
   int          mismatched;
   int          frames_seen;
   int          exp_frames;
   int          stray;
   int          fl_cnt;
   logic [23:0] flash_id;
   logic [23:0] fl_id;
   logic [23:0] model_id;
   logic [23:0] exp_q[$];

   rdid_top #(.DEBOUNCE_BITS(DB), .SPI_DIV(4)) dut (
      .CCLK         (CCLK),
      .reset_btn    (reset_btn),
      .get_rdid_btn (get_rdid_btn),
      .SW           (SW),
      .SPIMISO      (SPIMISO),
      .SPICLK       (SPICLK),
      .SPIMOSI      (SPIMOSI),
      .chip_select  (chip_select),
      .LD0(LD0), .LD1(LD1), .LD2(LD2), .LD3(LD3),
      .LD4(LD4), .LD5(LD5), .LD6(LD6), .LD7(LD7)
   );

   assign led = {LD7, LD6, LD5, LD4, LD3, LD2, LD1, LD0};

   initial CCLK = 1'b0;
   always #10 CCLK = ~CCLK;

   // Flash model: counts rising clocks, shifts ID out on falling ones.
   always @(negedge chip_select or posedge SPICLK) begin
      if (SPICLK == 1'b1 && chip_select == 1'b0) begin
         fl_cnt = fl_cnt + 1;
      end else if (chip_select == 1'b0) begin
         fl_cnt = 0;
         fl_id  = flash_id;
      end
   end

   always @(negedge SPICLK) begin
      if (chip_select == 1'b0 && fl_cnt >= 8 && fl_cnt < 32)
         SPIMISO = fl_id[31 - fl_cnt];
   end

   always @(posedge SPICLK) begin
      if (chip_select == 1'b1) stray = stray + 1;
   end

   function automatic logic [7:0] led_of(logic [23:0] id,
                                         logic [1:0] s);
      case (s)
         2'd0:    return id[7:0];
         2'd1:    return id[15:8];
         2'd2:    return id[23:16];
         default: return 8'hFF;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [7:0]  cmd;
      logic [23:0] e;
      int          pulses;
      forever begin
         @(negedge chip_select);
         pulses = 0;
         cmd    = '0;
         while (chip_select == 1'b0) begin
            @(posedge SPICLK or posedge chip_select);
            if (chip_select == 1'b0) begin
               pulses++;
               if (pulses <= 8) cmd = {cmd[6:0], SPIMOSI};
            end
         end
         if (reset_btn == 1'b0) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
         end else if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("frame_pulses", pulses, 32);
            check("frame_cmd", cmd, 8'h9F);
            @(negedge CCLK);
            @(negedge CCLK);
            check("frame_led", led, led_of(e, SW));
            frames_seen++;
         end
      end
   endtask

   task automatic press(int len);
      @(negedge CCLK);
      get_rdid_btn = 1'b1;
      repeat (len) @(negedge CCLK);
      get_rdid_btn = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(negedge CCLK);
   endtask

   task automatic new_id(logic [23:0] id);
      flash_id = id;
      exp_q.push_back(id);
      exp_frames++;
      model_id = id;
   endtask

   task automatic sweep();
      logic [1:0] keep;
      keep = SW;
      for (int s = 0; s < 4; s++) begin
         @(negedge CCLK);
         SW = 2'(s);
         #1;
         check($sformatf("led_sw%0d", s), led, led_of(model_id, SW));
      end
      SW = keep;
   endtask

   task automatic settle();
      idle(T + 260);
      check("frame_count", frames_seen, exp_frames);
   endtask

   initial begin
      int waited;
      compared     = 0;
      mismatched   = 0;
      frames_seen  = 0;
      exp_frames   = 0;
      stray        = 0;
      fl_cnt       = 0;
      fl_id        = '0;
      flash_id     = '0;
      model_id     = '0;
      SPIMISO      = 1'b0;
      SW           = 2'b00;
      get_rdid_btn = 1'b0;
      reset_btn    = 1'b0;
      fork
         monitor();
      join_none

      idle(10);
      check("rst_cs", chip_select, 1);
      check("rst_sclk", SPICLK, 0);
      check("rst_mosi", SPIMOSI, 0);
      sweep();
      reset_btn = 1'b1;
      idle(40);
      check("idle_no_sclk", stray, 0);
      sweep();

      for (int i = 0; i < 12; i++) begin
         press($urandom_range(1, T - 3));
         idle($urandom_range(1, T));
      end
      @(negedge CCLK);
      repeat (20) begin
         get_rdid_btn = ~get_rdid_btn;
         #1;
      end
      settle();

      new_id(24'h202015);
      @(negedge CCLK);
      for (int k = 0; k < 8; k++) begin
         get_rdid_btn = (k % 2 == 0);
         repeat ($urandom_range(1, T - 4)) @(negedge CCLK);
      end
      press(T + 8);
      settle();
      sweep();

      new_id(24'h202015);
      press(T + 8);
      settle();
      sweep();

      for (int i = 0; i < 5; i++) begin
         SW = 2'($urandom_range(0, 3));
         new_id(24'($urandom));
         press($urandom_range(T + 6, 4 * T));
         settle();
         sweep();
      end

      new_id(24'($urandom));
      press(12 * T);
      settle();
      sweep();

      new_id(24'($urandom));
      press(T + 8);
      idle(T + 8);
      press(T + 8);
      settle();
      sweep();

      SW = 2'b00;
      new_id(24'h202015);
      @(negedge CCLK);
      get_rdid_btn = 1'b1;
      waited = 0;
      while (chip_select == 1'b1 && waited < 200) begin
         @(negedge CCLK);
         waited++;
      end
      check("abort_frame_started", waited < 200, 1);
      idle(80);
      reset_btn = 1'b0;
      exp_frames--;
      model_id = '0;
      #1;
      check("abort_cs", chip_select, 1);
      check("abort_sclk", SPICLK, 0);
      check("abort_led", led, 8'h00);
      idle(3);
      get_rdid_btn = 1'b0;
      reset_btn    = 1'b1;
      idle(T + 8);
      sweep();

      new_id(24'h202015);
      press(T + 8);
      settle();
      sweep();

      check("queue_empty", exp_q.size(), 0);
      check("stray_sclk", stray, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
